nodf_module_intf: RTL and testbench
===================================

Name: nodf_module_intf

Overview:
- Passive, synthesizable observer for one non-dataflow HLS block's ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue).
- Sits beside the DUT top and never drives the DUT.
- Counts accepted and completed transactions, busy and stall cycles, and start-to-done latency (last/min/max).
- Freezes all statistics when the run-level finish signal asserts, so a dump stage can read them.

Parameters:
- CNT_W, 32, width of cycle timestamp and all counters.
- DEPTH, 4, maximum outstanding (started, not completed) transactions tracked for latency; power of two, ≥1.

Ports:
- clock  in  1  sampling clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ap_start  in  1  DUT start request.
- ap_ready  in  1  DUT ready; start accepted when ap_start&ap_ready.
- ap_done  in  1  DUT done.
- ap_continue  in  1  downstream continue; tie 1 if unused; completion = ap_done&ap_continue.
- finish  in  1  end-of-run indication.
- state  out  2  0 IDLE, 1 BUSY, 2 DONE_WAIT, 3 FINISHED.
- start_cnt  out  CNT_W  accepted starts.
- done_cnt  out  CNT_W  completions matched to a start.
- busy_cycles  out  CNT_W  cycles with outstanding>0.
- stall_cycles  out  CNT_W  cycles with ap_done=1, ap_continue=0.
- last_lat  out  CNT_W  latency of most recent completion.
- min_lat  out  CNT_W  minimum latency.
- max_lat  out  CNT_W  maximum latency.
- outstanding  out  clog2(DEPTH+1)  current outstanding count.
- err_overflow  out  1  sticky: start accepted while outstanding==DEPTH.
- err_underflow  out  1  sticky: completion with no outstanding start and no same-cycle start.
- finished  out  1  sticky: finish seen.

Behaviour:
- Reset (reset=0, async): all counters, last_lat, max_lat, outstanding, error and finished flags = 0; min_lat = all ones; state = IDLE; timestamp FIFO emptied.
- Free-running timestamp ts increments every cycle after reset release; wraps mod 2^CNT_W.
- Latency = ts_at_done − ts_at_start, mod 2^CNT_W.
- All outputs are registered and reflect events sampled at the previous posedge (1-cycle latency).
- Start (S = ap_start&ap_ready):
  - If outstanding<DEPTH: push ts into FIFO, start_cnt++.
  - If FIFO is full: start_cnt++, no push, set err_overflow.
- Completion (C = ap_done&ap_continue):
  - If FIFO is non-empty: pop oldest, compute latency, done_cnt++, update last_lat, min_lat (if smaller), max_lat (if larger).
  - If FIFO is empty and S in the same cycle: zero-latency transaction; start_cnt++, done_cnt++, latency 0, no push.
  - If FIFO is empty and no S: set err_underflow; no counter or latency update.
- S and C same cycle with a non-empty FIFO: pop then push; outstanding unchanged; the pop uses the oldest entry.
  - Applies even when the FIFO is full, in which case no overflow is flagged.
- busy_cycles increments when outstanding (pre-update) > 0.
- stall_cycles increments when ap_done & ~ap_continue.
- Counters wrap mod 2^CNT_W.
- State (next-state from updated values):
  - FINISHED if finished.
  - Else DONE_WAIT if ap_done & ~ap_continue.
  - Else BUSY if outstanding>0.
  - Else IDLE.
- finish sampled 1: finished←1, state←FINISHED. Events in that same cycle are still counted; from the next cycle everything is frozen. Only reset leaves FINISHED.
- Reset asserted mid-transaction discards all outstanding entries and statistics.
- Handshake inputs carrying X/Z are treated as 0.

Test Plan:
- Single transaction: reset release, ap_start=1 with ap_ready at cycle 10, ap_done=ap_continue=1 at cycle 17, then finish → start_cnt=1, done_cnt=1, last_lat=min_lat=max_lat=7, busy_cycles=7, err flags 0, state=3.
- Combinational transaction: ap_start, ap_ready and ap_done all 1 in the same cycle, FIFO empty → start_cnt=1, done_cnt=1, last_lat=0, min_lat=0, outstanding stays 0.
- Pipelined: starts at cycles 0,1,2,3 (DEPTH=4), dones at 5,6,8,9 → latencies 5,5,6,6; max_lat=6, min_lat=5; a fifth start at cycle 4 sets err_overflow=1 and start_cnt=5.
- Backpressure: ap_done=1, ap_continue=0 for 3 cycles, then ap_continue=1 → stall_cycles=3, state=2 during the stall, done_cnt increments once.
- Spurious done: ap_done=ap_continue=1 with no prior start → err_underflow=1, done_cnt=0, min_lat stays all ones.
- Freeze/reset: after finish=1, further starts/dones leave all outputs unchanged; driving reset=0 asynchronously mid-clock clears outputs to reset values immediately.

Source files
------------

// File: rtl/nodf_module_intf.sv
// Passive observer for an ap_ctrl (non-dataflow) HLS block: counts transactions,
// busy/stall cycles and start-to-done latency, and freezes everything once finish is seen.
module nodf_module_intf #(
    parameter  int CNT_W = 32,
    parameter  int DEPTH = 4,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] last_lat,
    output logic [CNT_W-1:0] min_lat,
    output logic [CNT_W-1:0] max_lat,
    output logic [OCC_W-1:0] outstanding,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic             finished
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_WAIT = 2'd2,
        ST_FINISHED  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ts_q, ts_d;
    logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             fin_q, fin_d;
    logic [CNT_W-1:0] mem_q [DEPTH];

    logic             s_s, c_s, stall_s, empty_s, full_s;
    logic             push_s, pop_s, zero_s, record_s;
    logic [CNT_W-1:0] lat_s;

    // Event decode and next-state for every statistic; all state holds once finished.
    always_comb begin
        s_s      = ap_start & ap_ready;
        c_s      = ap_done & ap_continue;
        stall_s  = ap_done & ~ap_continue;
        empty_s  = (occ_q == {OCC_W{1'b0}});
        full_s   = (occ_q == OCC_W'(DEPTH));
        pop_s    = 1'b0;
        push_s   = 1'b0;
        zero_s   = 1'b0;
        record_s = 1'b0;
        lat_s    = {CNT_W{1'b0}};

        ts_d        = ts_q;
        start_cnt_d = start_cnt_q;
        done_cnt_d  = done_cnt_q;
        busy_d      = busy_q;
        stall_d     = stall_q;
        last_d      = last_q;
        min_d       = min_q;
        max_d       = max_q;
        occ_d       = occ_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        fin_d       = fin_q;
        state_d     = state_q;

        if (!fin_q) begin
            pop_s    = c_s & ~empty_s;
            zero_s   = c_s & empty_s & s_s;
            // A same-cycle pop frees the slot, so a start on a full FIFO still lands.
            push_s   = s_s & ~zero_s & (~full_s | pop_s);
            record_s = pop_s | zero_s;
            if (pop_s) begin
                lat_s = ts_q - mem_q[rd_ptr_q];
            end else begin
                lat_s = {CNT_W{1'b0}};
            end

            ts_d = ts_q + CNT_ONE;
            if (s_s) begin
                start_cnt_d = start_cnt_q + CNT_ONE;
            end else begin
                start_cnt_d = start_cnt_q;
            end
            if (record_s) begin
                done_cnt_d = done_cnt_q + CNT_ONE;
                last_d     = lat_s;
                min_d      = (lat_s < min_q) ? lat_s : min_q;
                max_d      = (lat_s > max_q) ? lat_s : max_q;
            end else begin
                done_cnt_d = done_cnt_q;
            end
            if (!empty_s) begin
                busy_d = busy_q + CNT_ONE;
            end else begin
                busy_d = busy_q;
            end
            if (stall_s) begin
                stall_d = stall_q + CNT_ONE;
            end else begin
                stall_d = stall_q;
            end
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            occ_d = occ_q + OCC_W'(push_s) - OCC_W'(pop_s);
            ovf_d = ovf_q | (s_s & full_s & ~pop_s);
            unf_d = unf_q | (c_s & empty_s & ~s_s);
            fin_d = finish;

            if (fin_d) begin
                state_d = ST_FINISHED;
            end else if (stall_s) begin
                state_d = ST_DONE_WAIT;
            end else if (occ_d != {OCC_W{1'b0}}) begin
                state_d = ST_BUSY;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = ST_FINISHED;
        end
    end

    // Statistic and control registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ts_q        <= {CNT_W{1'b0}};
            start_cnt_q <= {CNT_W{1'b0}};
            done_cnt_q  <= {CNT_W{1'b0}};
            busy_q      <= {CNT_W{1'b0}};
            stall_q     <= {CNT_W{1'b0}};
            last_q      <= {CNT_W{1'b0}};
            min_q       <= {CNT_W{1'b1}};
            max_q       <= {CNT_W{1'b0}};
            occ_q       <= {OCC_W{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            start_cnt_q <= start_cnt_d;
            done_cnt_q  <= done_cnt_d;
            busy_q      <= busy_d;
            stall_q     <= stall_d;
            last_q      <= last_d;
            min_q       <= min_d;
            max_q       <= max_d;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            fin_q       <= fin_d;
        end
    end

    // Start-timestamp FIFO storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {CNT_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= ts_q;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign state         = state_q;
    assign start_cnt     = start_cnt_q;
    assign done_cnt      = done_cnt_q;
    assign busy_cycles   = busy_q;
    assign stall_cycles  = stall_q;
    assign last_lat      = last_q;
    assign min_lat       = min_q;
    assign max_lat       = max_q;
    assign outstanding   = occ_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
    assign finished      = fin_q;

endmodule

// File: tb/tb_nodf_module_intf.sv
// Scoreboard bench for nodf_module_intf: a queue-based reference model predicts every
// registered output per cycle; a monitor compares after each clock edge.
module tb_nodf_module_intf;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0, finish = 1'b0;
    logic [1:0]  state;
    logic [31:0] start_cnt, done_cnt, busy_cycles, stall_cycles, last_lat, min_lat, max_lat;
    logic [2:0]  outstanding;
    logic        err_overflow, err_underflow, finished;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] sc, dc, bc, stc, ll, mn, mx;
        logic [2:0]  occ;
        logic        ovf, unf, fin;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m;
    logic [31:0] fifo_q[$];
    logic [31:0] m_ts;

    nodf_module_intf #(.CNT_W(32), .DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish),
        .state(state), .start_cnt(start_cnt), .done_cnt(done_cnt),
        .busy_cycles(busy_cycles), .stall_cycles(stall_cycles),
        .last_lat(last_lat), .min_lat(min_lat), .max_lat(max_lat),
        .outstanding(outstanding), .err_overflow(err_overflow),
        .err_underflow(err_underflow), .finished(finished)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m.st = 2'd0; m.sc = 32'd0; m.dc = 32'd0; m.bc = 32'd0; m.stc = 32'd0;
        m.ll = 32'd0; m.mn = 32'hFFFF_FFFF; m.mx = 32'd0; m.occ = 3'd0;
        m.ovf = 1'b0; m.unf = 1'b0; m.fin = 1'b0;
        fifo_q.delete();
        m_ts = 32'd0;
    endtask

    task automatic record(input logic [31:0] lat);
        m.dc = m.dc + 32'd1;
        m.ll = lat;
        if (lat < m.mn) m.mn = lat;
        if (lat > m.mx) m.mx = lat;
    endtask

    // One sampled cycle: drive inputs, advance the reference model, queue the expectation.
    task automatic cycle(input logic st, input logic rdy, input logic dn, input logic cont, input logic fin);
        logic s, c;
        @(negedge clock);
        ap_start = st; ap_ready = rdy; ap_done = dn; ap_continue = cont; finish = fin;
        if (!m.fin) begin
            s = st & rdy;
            c = dn & cont;
            if (fifo_q.size() > 0) m.bc = m.bc + 32'd1;
            if (dn && !cont) m.stc = m.stc + 32'd1;
            if (s) m.sc = m.sc + 32'd1;
            if (c && fifo_q.size() > 0) begin
                record(m_ts - fifo_q.pop_front());
                if (s) fifo_q.push_back(m_ts);
            end else if (c && s) begin
                record(32'd0);
            end else if (c) begin
                m.unf = 1'b1;
            end else if (s) begin
                if (fifo_q.size() < 4) fifo_q.push_back(m_ts);
                else m.ovf = 1'b1;
            end
            m.occ = 3'(fifo_q.size());
            m.fin = fin;
            m.st  = fin ? 2'd3 : (dn && !cont) ? 2'd2 : (fifo_q.size() > 0) ? 2'd1 : 2'd0;
            m_ts  = m_ts + 32'd1;
        end
        exp_q.push_back(m);
    endtask

    // Monitor: compare every output once the edge the expectation describes has passed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("state", 32'(state), 32'(e.st));
                cmp("start_cnt", start_cnt, e.sc);
                cmp("done_cnt", done_cnt, e.dc);
                cmp("busy_cycles", busy_cycles, e.bc);
                cmp("stall_cycles", stall_cycles, e.stc);
                cmp("last_lat", last_lat, e.ll);
                cmp("min_lat", min_lat, e.mn);
                cmp("max_lat", max_lat, e.mx);
                cmp("outstanding", 32'(outstanding), 32'(e.occ));
                cmp("err_overflow", 32'(err_overflow), 32'(e.ovf));
                cmp("err_underflow", 32'(err_underflow), 32'(e.unf));
                cmp("finished", 32'(finished), 32'(e.fin));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        #2;
        cmp("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, "_state"}, 32'(state), 32'd0);
        cmp({tag, "_start_cnt"}, start_cnt, 32'd0);
        cmp({tag, "_done_cnt"}, done_cnt, 32'd0);
        cmp({tag, "_busy"}, busy_cycles, 32'd0);
        cmp({tag, "_stall"}, stall_cycles, 32'd0);
        cmp({tag, "_last_lat"}, last_lat, 32'd0);
        cmp({tag, "_min_lat"}, min_lat, 32'hFFFF_FFFF);
        cmp({tag, "_max_lat"}, max_lat, 32'd0);
        cmp({tag, "_outstanding"}, 32'(outstanding), 32'd0);
        cmp({tag, "_flags"}, {29'd0, err_overflow, err_underflow, finished}, 32'd0);
    endtask

    // Mid-cycle asynchronous reset, released mid-cycle so the next negedge starts cycle 0.
    task automatic do_reset(input string tag);
        drain();
        @(posedge clock);
        #3;
        reset = 1'b0;
        ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; ap_continue = 1'b0; finish = 1'b0;
        #1;
        check_reset_values(tag);
        @(posedge clock);
        #3;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        model_reset();
        #23;
        check_reset_values("por");
        @(posedge clock);
        #3;
        reset = 1'b1;

        // Single transaction: start at cycle 10, done at 17, then finish.
        idle(10);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(6);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clock); #1;
        cmp("single_last_lat", last_lat, 32'd7);
        cmp("single_busy", busy_cycles, 32'd7);
        cmp("single_state", 32'(state), 32'd3);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset("rst1");

        // Zero-latency transaction.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clock); #1;
        cmp("comb_last_lat", last_lat, 32'd0);
        cmp("comb_min_lat", min_lat, 32'd0);
        cmp("comb_outstanding", 32'(outstanding), 32'd0);
        do_reset("rst2");

        // Pipelined: starts 0..4 (fifth overflows), dones at 5,6,8,9.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clock); #1;
        cmp("pipe_max_lat", max_lat, 32'd6);
        cmp("pipe_min_lat", min_lat, 32'd5);
        cmp("pipe_ovf", 32'(err_overflow), 32'd1);
        cmp("pipe_start_cnt", start_cnt, 32'd5);
        do_reset("rst3");

        // Full FIFO with same-cycle start and done: no overflow.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);
        do_reset("rst4");

        // Backpressure: three stall cycles, then continue.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clock); #1;
        cmp("bp_stall", stall_cycles, 32'd3);
        cmp("bp_done_cnt", done_cnt, 32'd1);
        do_reset("rst5");

        // Spurious done.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clock); #1;
        cmp("spur_unf", 32'(err_underflow), 32'd1);
        cmp("spur_done_cnt", done_cnt, 32'd0);
        cmp("spur_min_lat", min_lat, 32'hFFFF_FFFF);
        do_reset("rst6");

        // Randomised traffic, then finish, then frozen traffic.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 8),
                  1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 7), 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++)
            cycle(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        do_reset("rst_final");

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
